wb_imem_responder: RTL and testbench



---
 rtl/wb_imem_responder.sv | 108 ++++++++++
 tb/tb_wb_imem_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_imem_responder.sv
// Wishbone pipelined instruction-memory responder.
// Fixed-latency read pipeline with a side-band load port. Requests that write or fall
// outside the memory get an ERR instead of an ACK. Dropping CYC aborts everything in flight.
module wb_imem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned AW        = 28,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  input  logic                         i_wb_we,
  input  logic [AW-1:0]                i_wb_addr,
  input  logic [31:0]                  i_wb_data,
  output logic                         o_wb_stall,
  output logic                         o_wb_ack,
  output logic                         o_wb_err,
  output logic [31:0]                  o_wb_data,
  input  logic                         i_hold,
  input  logic                         i_ld_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_ld_addr,
  input  logic [31:0]                  i_ld_data,
  output logic [2:0]                   o_outstanding
);

  localparam int unsigned MAW = $clog2(MEM_WORDS);
  localparam int unsigned AWX = AW + 1;

  logic [31:0]        mem [MEM_WORDS];
  logic [31:0]        data_q [LATENCY];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [2:0]         outst_q, outst_d;

  logic accept, addr_oob, req_err, rd_en, resp;

  // Write data is never stored; the bus is read-only.
  logic unused_wdata;
  assign unused_wdata = ^i_wb_data;

  // A load occupies the memory port for its cycle, so it stalls the bus.
  assign o_wb_stall = i_hold | i_ld_we;
  assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  // Extra MSB so MEM_WORDS == 2**AW still compares correctly.
  assign addr_oob   = {1'b0, i_wb_addr} >= AWX'(MEM_WORDS);
  assign req_err    = i_wb_we | addr_oob;
  assign rd_en      = accept & ~req_err;
  assign resp       = vld_q[LATENCY-1];

  // Next state of the valid/err shift pipeline; CYC low flushes it.
  always_comb begin
    vld_d = '0;
    err_d = '0;
    if (i_wb_cyc) begin
      vld_d[0] = accept;
      err_d[0] = accept & req_err;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
      end
    end
  end

  // Outstanding count: +1 on accept, -1 as the final stage responds, cleared on abort.
  always_comb begin
    outst_d = outst_q;
    if (!i_wb_cyc) begin
      outst_d = '0;
    end else begin
      outst_d = outst_q + {2'b00, accept} - {2'b00, resp};
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_q   <= '0;
      err_q   <= '0;
      outst_q <= '0;
    end else begin
      vld_q   <= vld_d;
      err_q   <= err_d;
      outst_q <= outst_d;
    end
  end

  // Block RAM with load port and registered read (stage 0), plus the data shift stages.
  // Kept unreset so the array and read register map onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (i_ld_we) begin
      mem[i_ld_addr] <= i_ld_data;
    end
    if (rd_en) begin
      data_q[0] <= mem[i_wb_addr[MAW-1:0]];
    end
    for (int i = 1; i < int'(LATENCY); i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign o_wb_ack      = resp & ~err_q[LATENCY-1];
  assign o_wb_err      = resp & err_q[LATENCY-1];
  // Stale read data is masked whenever no ACK is being issued.
  assign o_wb_data     = o_wb_ack ? data_q[LATENCY-1] : 32'h0;
  assign o_outstanding = outst_q;

endmodule

// File: tb/tb_wb_imem_responder.sv
// Bench for wb_imem_responder: directed vector table, hand sequences and random traffic.
// A queue of expected responses with due cycles serves as the reference model.
module tb_wb_imem_responder;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned AW        = 28;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned MAW       = 10;

  logic             clk, i_reset_n;
  logic             i_wb_cyc, i_wb_stb, i_wb_we;
  logic [AW-1:0]    i_wb_addr;
  logic [31:0]      i_wb_data;
  logic             o_wb_stall, o_wb_ack, o_wb_err;
  logic [31:0]      o_wb_data;
  logic             i_hold, i_ld_we;
  logic [MAW-1:0]   i_ld_addr;
  logic [31:0]      i_ld_data;
  logic [2:0]       o_outstanding;

  wb_imem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW),
    .LATENCY  (LATENCY)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_wb_cyc     (i_wb_cyc),
    .i_wb_stb     (i_wb_stb),
    .i_wb_we      (i_wb_we),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .o_wb_stall   (o_wb_stall),
    .o_wb_ack     (o_wb_ack),
    .o_wb_err     (o_wb_err),
    .o_wb_data    (o_wb_data),
    .i_hold       (i_hold),
    .i_ld_we      (i_ld_we),
    .i_ld_addr    (i_ld_addr),
    .i_ld_data    (i_ld_data),
    .o_outstanding(o_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           cyc, stb, we;
    logic [AW-1:0]  addr;
    logic           hold, ld_we;
    logic [MAW-1:0] ld_addr;
    logic [31:0]    ld_data;
  } stim_t;

  typedef struct {
    logic        stall, ack, err;
    logic [31:0] data;
    logic [2:0]  outst;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    longint      due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] shadow [MEM_WORDS];
  longint      cyc_n;
  int          n_tests, n_fail;
  int          seen_resp, model_acc, peak_out;
  logic        last_acc;
  logic [31:0] last_ack_data;
  vec_t        vt[$];

  function automatic stim_t idle();
    stim_t s;
    s.cyc = 1'b1; s.stb = 1'b0; s.we = 1'b0; s.addr = '0;
    s.hold = 1'b0; s.ld_we = 1'b0; s.ld_addr = '0; s.ld_data = '0;
    return s;
  endfunction

  function automatic stim_t rd(input int a);
    stim_t s;
    s = idle();
    s.stb = 1'b1;
    s.addr = AW'(a);
    return s;
  endfunction

  function automatic stim_t wr(input int a);
    stim_t s;
    s = rd(a);
    s.we = 1'b1;
    return s;
  endfunction

  function automatic stim_t ld(input int a, input logic [31:0] d);
    stim_t s;
    s = idle();
    s.ld_we = 1'b1;
    s.ld_addr = MAW'(a);
    s.ld_data = d;
    return s;
  endfunction

  function automatic stim_t abort_s();
    stim_t s;
    s = idle();
    s.cyc = 1'b0;
    return s;
  endfunction

  function automatic exp_t ex(input logic st, input logic a, input logic e,
                              input logic [31:0] d, input logic [2:0] o);
    exp_t x;
    x.stall = st; x.ack = a; x.err = e; x.data = d; x.outst = o;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    i_wb_cyc  = s.cyc;
    i_wb_stb  = s.stb;
    i_wb_we   = s.we;
    i_wb_addr = s.addr;
    i_wb_data = $urandom;
    i_hold    = s.hold;
    i_ld_we   = s.ld_we;
    i_ld_addr = s.ld_addr;
    i_ld_data = s.ld_data;
  endtask

  // Compare the current cycle's outputs against the response queue.
  task automatic check_model();
    logic        e_ack, e_err;
    logic [31:0] e_data;
    e_ack = 1'b0; e_err = 1'b0; e_data = '0;
    if (q.size() > 0 && q[0].due == cyc_n) begin
      e_ack  = !q[0].err;
      e_err  = q[0].err;
      e_data = q[0].err ? 32'h0 : q[0].data;
    end
    chk("stall", o_wb_stall, i_hold | i_ld_we);
    chk("ack", o_wb_ack, e_ack);
    chk("err", o_wb_err, e_err);
    chk("data", o_wb_data, e_data);
    chk("outstanding", o_outstanding, q.size());
    chk("ack_err_exclusive", o_wb_ack & o_wb_err, 0);
    if (o_wb_ack || o_wb_err) seen_resp++;
    if (o_wb_ack) last_ack_data = o_wb_data;
    if (int'(o_outstanding) > peak_out) peak_out = int'(o_outstanding);
  endtask

  // Advance the model across one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    rsp_t r;
    cyc_n++;
    while (q.size() > 0 && q[0].due < cyc_n) void'(q.pop_front());
    last_acc = i_wb_cyc && i_wb_stb && !(i_hold || i_ld_we);
    if (!i_wb_cyc) begin
      q.delete();
    end else if (last_acc) begin
      r.due  = cyc_n + longint'(LATENCY) - 1;
      r.err  = i_wb_we || (i_wb_addr >= MEM_WORDS);
      r.data = r.err ? 32'h0 : shadow[i_wb_addr[MAW-1:0]];
      q.push_back(r);
      model_acc++;
    end
    if (i_ld_we) shadow[i_ld_addr] = i_ld_data;
  endtask

  task automatic tick(input stim_t s, input bit use_e, input exp_t e, input int idx);
    @(negedge clk);
    drive(s);
    #1;
    check_model();
    if (use_e) begin
      chk($sformatf("vec%0d_stall", idx), o_wb_stall, e.stall);
      chk($sformatf("vec%0d_ack", idx), o_wb_ack, e.ack);
      chk($sformatf("vec%0d_err", idx), o_wb_err, e.err);
      chk($sformatf("vec%0d_data", idx), o_wb_data, e.data);
      chk($sformatf("vec%0d_outstanding", idx), o_outstanding, e.outst);
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic run(input stim_t s);
    tick(s, 1'b0, ex(0, 0, 0, 0, 0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int    snap, snap_acc, nxt;
    stim_t s;
    n_tests = 0; n_fail = 0; seen_resp = 0; model_acc = 0; peak_out = 0;
    cyc_n = 0; last_acc = 1'b0; last_ack_data = '0;

    // Reset state.
    drive(idle());
    i_reset_n = 1'b0;
    #1;
    chk("reset_ack", o_wb_ack, 0);
    chk("reset_err", o_wb_err, 0);
    chk("reset_data", o_wb_data, 0);
    chk("reset_outstanding", o_outstanding, 0);
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;

    // Hand-derived vectors: single read, error responses, hold stall.
    vt.push_back('{ld(3, 32'hA5A5_0003), ex(1, 0, 0, 32'h0, 0)});
    vt.push_back('{ld(5, 32'h1234_5678), ex(1, 0, 0, 32'h0, 0)});
    vt.push_back('{rd(5),                ex(0, 0, 0, 32'h0, 0)});
    vt.push_back('{idle(),               ex(0, 0, 0, 32'h0, 1)});
    vt.push_back('{idle(),               ex(0, 1, 0, 32'h1234_5678, 1)});
    vt.push_back('{idle(),               ex(0, 0, 0, 32'h0, 0)});
    vt.push_back('{rd(1024),             ex(0, 0, 0, 32'h0, 0)});
    vt.push_back('{wr(3),                ex(0, 0, 0, 32'h0, 1)});
    vt.push_back('{idle(),               ex(0, 0, 1, 32'h0, 2)});
    vt.push_back('{idle(),               ex(0, 0, 1, 32'h0, 1)});
    vt.push_back('{rd(3),                ex(0, 0, 0, 32'h0, 0)});
    vt.push_back('{idle(),               ex(0, 0, 0, 32'h0, 1)});
    vt.push_back('{idle(),               ex(0, 1, 0, 32'hA5A5_0003, 1)});
    s = rd(5);
    s.hold = 1'b1;
    vt.push_back('{s,                    ex(1, 0, 0, 32'h0, 0)});
    vt.push_back('{idle(),               ex(0, 0, 0, 32'h0, 0)});
    vt.push_back('{idle(),               ex(0, 0, 0, 32'h0, 0)});
    for (int i = 0; i < vt.size(); i++) tick(vt[i].s, 1'b1, vt[i].e, i);

    // Preload words 0..15 (5 keeps its value from the table).
    for (int a = 0; a < 16; a++) begin
      if (a != 5) run(ld(a, $urandom));
    end

    // Back-to-back burst of 8 reads.
    snap = seen_resp;
    peak_out = 0;
    for (int a = 0; a < 8; a++) run(rd(a));
    repeat (3) run(idle());
    chk("burst_ack_count", seen_resp - snap, 8);
    chk("burst_peak_outstanding", peak_out, 2);

    // Abort one cycle after the second accept.
    run(rd(0));
    run(rd(1));
    run(abort_s());
    snap = seen_resp;
    repeat (3) run(idle());
    chk("abort_no_resp", seen_resp - snap, 0);
    chk("abort_outstanding", o_outstanding, 0);
    // Abort followed immediately by a request.
    run(rd(2));
    run(abort_s());
    run(rd(7));
    repeat (3) run(idle());

    // Burst with a 3-cycle hold and one load; STB held until accepted.
    snap = seen_resp;
    snap_acc = model_acc;
    nxt = 0;
    for (int c = 0; c < 40 && nxt < 10; c++) begin
      s = rd(nxt);
      if (c >= 3 && c < 6) s.hold = 1'b1;
      if (c == 8) begin
        s.ld_we = 1'b1;
        s.ld_addr = 9;
        s.ld_data = 32'hDEAD_0009;
      end
      run(s);
      if (last_acc) nxt++;
    end
    repeat (3) run(idle());
    chk("stall_burst_accepts", model_acc - snap_acc, 10);
    chk("stall_burst_resp_eq_acc", seen_resp - snap, model_acc - snap_acc);

    // Reset with two requests outstanding; memory must survive.
    run(rd(5));
    run(rd(6));
    @(negedge clk);
    drive(idle());
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("midreset_ack", o_wb_ack, 0);
    chk("midreset_err", o_wb_err, 0);
    chk("midreset_data", o_wb_data, 0);
    chk("midreset_outstanding", o_outstanding, 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    snap = seen_resp;
    repeat (5) run(idle());
    chk("postreset_no_resp", seen_resp - snap, 0);
    chk("postreset_outstanding", o_outstanding, 0);
    last_ack_data = '0;
    run(rd(5));
    repeat (3) run(idle());
    chk("postreset_mem_kept", last_ack_data, 32'h1234_5678);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      int r;
      s = idle();
      s.cyc = ($urandom_range(0, 19) != 0);
      s.stb = ($urandom_range(0, 3) != 0);
      s.we  = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      s.addr = AW'(1024 + $urandom_range(0, 7));
      else if (r == 1) s.addr = AW'($urandom_range(1024, 32'h0FFF_FFFF));
      else             s.addr = AW'($urandom_range(0, 15));
      s.hold    = ($urandom_range(0, 5) == 0);
      s.ld_we   = ($urandom_range(0, 7) == 0);
      s.ld_addr = MAW'($urandom_range(0, 15));
      s.ld_data = $urandom;
      run(s);
    end
    repeat (4) run(idle());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
